// File: rtl/mem_io_pkg.sv
// Shared constants, FSM state encoding and address-region codes for the
// memory/IO load-store sequencer.
package mem_io_pkg;

  localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;

  localparam int MEM_LAT_DEF = 1;
  localparam int MEM_AW_DEF  = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_MEM_WR = 3'd2,
    ST_IO     = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_MEM = 2'd0,
    REG_LED = 2'd1,
    REG_SW  = 2'd2,
    REG_ERR = 2'd3
  } region_e;

endpackage

// File: rtl/mem_io_decode.sv
// Combinational address decode: byte address plus direction -> target region.
// Misalignment is checked first so it overrides every other match.
module mem_io_decode #(
  parameter logic [31:0] IO_BASE  = mem_io_pkg::IO_BASE,
  parameter logic [31:0] LED_ADDR = mem_io_pkg::LED_ADDR,
  parameter logic [31:0] SW_ADDR  = mem_io_pkg::SW_ADDR
) (
  input  logic [31:0]         addr_i,
  input  logic                write_i,
  output mem_io_pkg::region_e region_o
);

  always_comb begin
    region_o = mem_io_pkg::REG_ERR;
    if (addr_i[1:0] != 2'b00) begin
      region_o = mem_io_pkg::REG_ERR;
    end else if (addr_i < IO_BASE) begin
      region_o = mem_io_pkg::REG_MEM;
    end else if ((addr_i == LED_ADDR) && write_i) begin
      region_o = mem_io_pkg::REG_LED;
    end else if ((addr_i == SW_ADDR) && !write_i) begin
      region_o = mem_io_pkg::REG_SW;
    end
  end

endmodule

// File: rtl/mem_io_seq.sv
// Load/store sequencer: accepts one request at a time, runs the block-RAM read,
// one-cycle write strobe or LED/switch access, then emits a one-cycle response.
module mem_io_seq #(
  parameter int          MEM_LAT  = mem_io_pkg::MEM_LAT_DEF,
  parameter int          MEM_AW   = mem_io_pkg::MEM_AW_DEF,
  parameter logic [31:0] IO_BASE  = mem_io_pkg::IO_BASE,
  parameter logic [31:0] LED_ADDR = mem_io_pkg::LED_ADDR,
  parameter logic [31:0] SW_ADDR  = mem_io_pkg::SW_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // the requester holds its inputs stable until then. resp_valid is a one-cycle
  // pulse with no back-pressure; resp_rdata/resp_err hold until the next response.
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic [15:0]       sw_data,
  output logic [15:0]       led_out
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mem_io_pkg::state_e  state_q;
  mem_io_pkg::region_e region;
  logic [CW-1:0]       cnt_q;
  logic                is_wr_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                mem_we_q;
  logic [15:0]         led_q;

  mem_io_decode #(
    .IO_BASE (IO_BASE),
    .LED_ADDR(LED_ADDR),
    .SW_ADDR (SW_ADDR)
  ) u_decode (
    .addr_i  (req_addr),
    .write_i (req_write),
    .region_o(region)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= mem_io_pkg::ST_IDLE;
      cnt_q        <= '0;
      is_wr_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      led_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        mem_io_pkg::ST_IDLE: begin
          if (req_valid) begin
            mem_addr_q  <= req_addr[MEM_AW+1:2];
            mem_wdata_q <= req_wdata;
            is_wr_q     <= req_write;
            cnt_q       <= '0;
            case (region)
              mem_io_pkg::REG_MEM: begin
                if (req_write) begin
                  state_q  <= mem_io_pkg::ST_MEM_WR;
                  mem_we_q <= 1'b1;
                end else begin
                  state_q  <= mem_io_pkg::ST_MEM_RD;
                end
              end
              mem_io_pkg::REG_LED, mem_io_pkg::REG_SW: state_q <= mem_io_pkg::ST_IO;
              default: begin
                // Rejected request: respond next cycle with no side effects.
                state_q      <= mem_io_pkg::ST_RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b1;
                resp_rdata_q <= '0;
              end
            endcase
          end
        end
        mem_io_pkg::ST_MEM_RD: begin
          if (cnt_q == CW'(MEM_LAT - 1)) begin
            state_q      <= mem_io_pkg::ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        mem_io_pkg::ST_MEM_WR: begin
          state_q      <= mem_io_pkg::ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        mem_io_pkg::ST_IO: begin
          state_q      <= mem_io_pkg::ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          if (is_wr_q) begin
            led_q        <= mem_wdata_q[15:0];
            resp_rdata_q <= '0;
          end else begin
            resp_rdata_q <= {16'h0000, sw_data};
          end
        end
        mem_io_pkg::ST_RESP: state_q <= mem_io_pkg::ST_IDLE;
        default:             state_q <= mem_io_pkg::ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == mem_io_pkg::ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign led_out    = led_q;

endmodule
